// File: rtl/sum_window_accum.sv
// Window accumulator: sums COUNT accepted samples, or fewer when flushed early,
// then holds the saturating total on a valid/ready port until it is taken.
module sum_window_accum #(
    parameter int WIDTH = 32,
    parameter int ACC_W = 40,
    parameter int COUNT = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_sat,
    output logic             out_valid,
    input  logic             out_ready
);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t           state, state_nx;
    logic [ACC_W-1:0] acc, acc_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             sat, sat_nx;
    logic             load;
    logic             accept;
    logic [ACC_W:0]   sum_w;

    // Bit ACC_W of the result flags a carry; the value clamps to all-ones.
    function automatic logic [ACC_W:0] add_sat(input logic [ACC_W-1:0] a,
                                               input logic [WIDTH-1:0] b);
        logic [ACC_W:0] s;
        s = {1'b0, a} + (ACC_W+1)'(b);
        if (s[ACC_W])
            add_sat = {1'b1, {ACC_W{1'b1}}};
        else
            add_sat = s;
    endfunction

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == HOLD);
    assign accept    = in_valid & in_ready;
    assign sum_w     = add_sat(acc, in_data);

    always_comb begin
        state_nx = state;
        acc_nx   = acc;
        cnt_nx   = cnt;
        sat_nx   = sat;
        load     = 1'b0;
        case (state)
            ACCUM: begin
                if (accept) begin
                    acc_nx = sum_w[ACC_W-1:0];
                    sat_nx = sat | sum_w[ACC_W];
                    cnt_nx = cnt + CNT_W'(1);
                end
                // A flush with nothing collected and no sample this cycle is a no-op.
                if ((accept && cnt_nx == CNT_W'(COUNT)) ||
                    (flush && (cnt != '0 || accept))) begin
                    state_nx = HOLD;
                    load     = 1'b1;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_nx = ACCUM;
                    acc_nx   = '0;
                    cnt_nx   = '0;
                    sat_nx   = 1'b0;
                end
            end
            default: state_nx = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACCUM;
            acc       <= '0;
            cnt       <= '0;
            sat       <= 1'b0;
            out_sum   <= '0;
            out_count <= '0;
            out_sat   <= 1'b0;
        end else begin
            state <= state_nx;
            acc   <= acc_nx;
            cnt   <= cnt_nx;
            sat   <= sat_nx;
            if (load) begin
                out_sum   <= acc_nx;
                out_count <= cnt_nx;
                out_sat   <= sat_nx;
            end
        end
    end

endmodule

// File: tb/tb_sum_window_accum.sv
// Bench for sum_window_accum: queue-based window model checked every cycle,
// plus directed literal checks on a default and a narrow saturating instance.
module tb_sum_window_accum;

    localparam int WIDTH = 32, ACC_W = 40, COUNT = 8, CNT_W = 16;
    localparam int S_W = 8, S_COUNT = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             flush = 1'b0;
    logic [ACC_W-1:0] out_sum;
    logic [CNT_W-1:0] out_count;
    logic             out_sat;
    logic             out_valid;
    logic             out_ready = 1'b1;

    logic [S_W-1:0]   s_in_data = '0;
    logic             s_in_valid = 1'b0;
    logic             s_in_ready;
    logic             s_flush = 1'b0;
    logic [S_W-1:0]   s_out_sum;
    logic [CNT_W-1:0] s_out_count;
    logic             s_out_sat;
    logic             s_out_valid;
    logic             s_out_ready = 1'b1;

    int tests = 0;
    int fails = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    sum_window_accum #(.WIDTH(WIDTH), .ACC_W(ACC_W), .COUNT(COUNT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .flush(flush), .out_sum(out_sum), .out_count(out_count), .out_sat(out_sat),
        .out_valid(out_valid), .out_ready(out_ready));

    sum_window_accum #(.WIDTH(S_W), .ACC_W(S_W), .COUNT(S_COUNT), .CNT_W(CNT_W)) dut_s (
        .clk(clk), .rst(rst), .in_data(s_in_data), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .flush(s_flush), .out_sum(s_out_sum), .out_count(s_out_count), .out_sat(s_out_sat),
        .out_valid(s_out_valid), .out_ready(s_out_ready));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Window model: collect accepted samples in a queue, close on COUNT or flush.
    longint win_q[$];
    bit     m_hold = 1'b0;
    longint m_sum = 0;
    int     m_cnt = 0;
    bit     m_sat = 1'b0;

    always @(posedge clk) begin
        longint total;
        longint maxv;
        maxv = (longint'(1) << ACC_W) - 1;
        if (rst) begin
            win_q.delete();
            m_hold = 1'b0;
        end else if (!m_hold) begin
            if (in_valid) win_q.push_back(longint'(in_data));
            if (win_q.size() == COUNT || (flush && win_q.size() > 0)) begin
                total = 0;
                foreach (win_q[i]) total += win_q[i];
                m_sat  = (total > maxv);
                m_sum  = m_sat ? maxv : total;
                m_cnt  = win_q.size();
                m_hold = 1'b1;
                win_q.delete();
            end
        end else if (out_ready) begin
            m_hold = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("m_in_ready", 64'(in_ready), 64'(!m_hold));
            chk("m_out_valid", 64'(out_valid), 64'(m_hold));
            if (m_hold) begin
                chk("m_out_sum", 64'(out_sum), 64'(m_sum));
                chk("m_out_count", 64'(out_count), 64'(m_cnt));
                chk("m_out_sat", 64'(out_sat), 64'(m_sat));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [WIDTH-1:0] v);
        in_valid = 1'b1;
        in_data  = v;
        step();
        in_valid = 1'b0;
    endtask

    task automatic s_feed(input logic [S_W-1:0] v);
        s_in_valid = 1'b1;
        s_in_data  = v;
        step();
        s_in_valid = 1'b0;
    endtask

    initial begin
        // Reset with in_valid held high
        rst = 1'b1; in_valid = 1'b1; in_data = 32'd77; s_in_valid = 1'b1; s_in_data = 8'd9;
        step(); step();
        check_en = 1'b1;
        rst = 1'b0; in_valid = 1'b0; s_in_valid = 1'b0;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_sum", 64'(out_sum), 64'd0);
        chk("rst_out_count", 64'(out_count), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_s_out_valid", 64'(s_out_valid), 64'd0);

        // Full window 5..12
        for (int i = 0; i < 8; i++) feed(32'(5 + i));
        chk("full_sum", 64'(out_sum), 64'd68);
        chk("full_count", 64'(out_count), 64'd8);
        chk("full_sat", 64'(out_sat), 64'd0);
        chk("full_valid", 64'(out_valid), 64'd1);
        step();
        chk("full_pulse_end", 64'(out_valid), 64'd0);
        chk("full_ready_back", 64'(in_ready), 64'd1);

        // Backpressure
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) feed(32'(5 + i));
        in_valid = 1'b1; in_data = 32'd99;
        for (int i = 0; i < 10; i++) begin
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_sum_held", 64'(out_sum), 64'd68);
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("bp_valid_before", 64'(out_valid), 64'd1);
        step();
        chk("bp_released", 64'(out_valid), 64'd0);
        chk("bp_accum", 64'(in_ready), 64'd1);

        // Flush with a sample, then idle flush
        feed(32'd1); feed(32'd2); feed(32'd3);
        flush = 1'b1;
        feed(32'd4);
        flush = 1'b0;
        chk("flush_sum", 64'(out_sum), 64'd10);
        chk("flush_count", 64'(out_count), 64'd4);
        step();
        flush = 1'b1;
        step(); step();
        chk("idle_flush_valid", 64'(out_valid), 64'd0);
        flush = 1'b0;
        step();

        // Saturation on the narrow instance
        s_feed(8'd200); s_feed(8'd100); s_feed(8'd1); s_feed(8'd1);
        chk("sat_sum", 64'(s_out_sum), 64'd255);
        chk("sat_flag", 64'(s_out_sat), 64'd1);
        chk("sat_count", 64'(s_out_count), 64'd4);
        step();
        s_feed(8'd1); s_feed(8'd2); s_feed(8'd3); s_feed(8'd4);
        chk("sat_next_sum", 64'(s_out_sum), 64'd10);
        chk("sat_next_flag", 64'(s_out_sat), 64'd0);
        step();

        // Reset mid-window
        for (int i = 0; i < 5; i++) feed(32'd3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) feed(32'd1);
        chk("midrst_sum", 64'(out_sum), 64'd8);
        chk("midrst_count", 64'(out_count), 64'd8);
        step(); step();

        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
